// File: rtl/relu_neuron_ctrl_pkg.sv
// Shared definitions for the ReLU neuron controller.
//   state_t    : FSM state encoding (IDLE / ACC / RELU / OUT)
//   acc_width  : accumulator width, wide enough that N_INPUTS full products
//                (plus an optional 2*WIDTH bias) can never wrap
//   cnt_width  : operand counter width, at least 1 bit even for N_INPUTS == 1
package relu_neuron_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RELU = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic int acc_width(input int width, input int n_inputs);
    return 2 * width + $clog2(n_inputs) + 1;
  endfunction

  function automatic int cnt_width(input int n_inputs);
    return (n_inputs > 1) ? $clog2(n_inputs) : 1;
  endfunction

endpackage

// File: rtl/relu_neuron_ctrl_relu.sv
// Combinational ReLU datapath.
// Takes an already clamped 2*WIDTH signed value and returns the WIDTH-bit
// activation: zero for non-positive inputs, otherwise the upper WIDTH bits.
// Ports:
//   din   in  2*WIDTH  signed, clamped pre-activation value
//   dout  out WIDTH    unsigned activation
module relu_neuron_ctrl_relu #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] din,
  output logic [WIDTH-1:0]   dout
);

  logic positive;

  // Strictly positive: sign clear and at least one magnitude bit set.
  assign positive = !din[2*WIDTH-1] && (|din[2*WIDTH-2:0]);

  always_comb begin
    dout = '0;
    if (positive) begin
      dout = din[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/relu_neuron_ctrl.sv
// ReLU neuron sequencer.
// Accepts N_INPUTS signed (x, w) pairs over a valid/ready stream, multiply-
// accumulates them, saturates the sum to 2*WIDTH signed, applies ReLU and
// presents the WIDTH-bit activation on a valid/ready output.
// Optional feature macro: RELU_BIAS_EN (adds the bias port; the accumulator
// is preloaded with the sign-extended bias on start).
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        begin an evaluation (honoured only in IDLE)
//   busy       out  1        high in every state except IDLE
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        high in ACC
//   in_x       in   WIDTH    signed activation operand
//   in_w       in   WIDTH    signed weight operand
//   out_valid  out  1        activation valid, held until out_ready
//   out_ready  in   1        downstream accepts activation
//   out_data   out  WIDTH    ReLU result
//   out_sat    out  1        accumulator saturated in this evaluation
//   bias       in   2*WIDTH  signed bias sampled with start (RELU_BIAS_EN)
//
// state | meaning
// IDLE  | waiting for start; no operands accepted
// ACC   | accepting operand pairs and accumulating products
// RELU  | clamp accumulator, register activation and saturation flag
// OUT   | holding activation until out_ready
module relu_neuron_ctrl
  import relu_neuron_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
) (
`ifdef RELU_BIAS_EN
  input  logic signed [2*WIDTH-1:0] bias,
`endif
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_x,
  input  logic signed [WIDTH-1:0]   in_w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_sat
);

  localparam int P_W   = 2 * WIDTH;
  localparam int ACC_W = acc_width(WIDTH, N_INPUTS);
  localparam int CNT_W = cnt_width(N_INPUTS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         count;

  logic signed [P_W-1:0]    product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  acc_init;
  logic [ACC_W-P_W:0]       acc_head;
  logic                     in_range;
  logic [P_W-1:0]           clamped;
  logic [WIDTH-1:0]         relu_out;
  logic                     handshake;

  assign handshake = in_valid && in_ready;

  always_comb begin
    // Both operands are signed, so they are sign-extended to 2*WIDTH before
    // the multiply; (-2^(W-1))^2 fits without overflow.
    product     = in_x * in_w;
    product_ext = {{(ACC_W-P_W){product[P_W-1]}}, product};

`ifdef RELU_BIAS_EN
    acc_init = {{(ACC_W-P_W){bias[P_W-1]}}, bias};
`else
    acc_init = '0;
`endif

    // The accumulator fits 2*WIDTH signed exactly when every bit from the
    // 2*WIDTH sign position upward agrees.
    acc_head = acc[ACC_W-1:P_W-1];
    in_range = (&acc_head) || !(|acc_head);

    clamped = acc[P_W-1:0];
    if (!in_range) begin
      clamped = acc[ACC_W-1] ? {1'b1, {(P_W-1){1'b0}}}
                             : {1'b0, {(P_W-1){1'b1}}};
    end
  end

  relu_neuron_ctrl_relu #(
    .WIDTH (WIDTH)
  ) u_relu (
    .din  (clamped),
    .dout (relu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ACC;
            acc      <= acc_init;
            count    <= '0;
            out_sat  <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end

        ST_ACC: begin
          if (handshake) begin
            acc   <= acc + product_ext;
            count <= count + CNT_W'(1);
            if (count == LAST_CNT) begin
              state    <= ST_RELU;
              in_ready <= 1'b0;
            end
          end
        end

        ST_RELU: begin
          out_data  <= relu_out;
          out_sat   <= !in_range;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
